// File: rtl/nios_system_pio_edge_in_if.sv
// Avalon-MM slave bus plus interrupt line for the edge-capture PIO.
interface nios_system_pio_edge_in_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/nios_system_pio_edge_in.sv
// Edge-capture input PIO: per-bit synchroniser, edge detector and sticky capture
// bit, with an Avalon register file (data / reserved / irqmask / edge_capture).

module nios_system_pio_edge_in_lane #(
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_in,
  input  logic i_clr,
  output logic o_sync,
  output logic o_cap
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   r_cap;
  logic                   w_edge;

  always_comb begin
    w_edge = 1'b0;
    case (EDGE_TYPE)
      0:       w_edge =  r_sync[SYNC_STAGES-1] & ~r_sync_d;
      1:       w_edge = ~r_sync[SYNC_STAGES-1] &  r_sync_d;
      default: w_edge =  r_sync[SYNC_STAGES-1] ^  r_sync_d;
    endcase
  end

  // Set has priority over a same-cycle software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
      r_cap    <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], i_in};
      r_sync_d <= r_sync[SYNC_STAGES-1];
      r_cap    <= w_edge | (r_cap & ~i_clr);
    end
  end

  assign o_sync = r_sync[SYNC_STAGES-1];
  assign o_cap  = r_cap;
endmodule

module nios_system_pio_edge_in #(
  parameter int WIDTH       = 8,
  parameter int EDGE_TYPE   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [WIDTH-1:0]         in_port,
  nios_system_pio_edge_in_if.slave bus
);
  logic [WIDTH-1:0] w_sync;
  logic [WIDTH-1:0] w_cap;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_irqmask;
  logic [31:0]      r_readdata;
  logic [31:0]      w_rdata;
  logic             r_irq;
  logic             w_wr;
  logic             w_unused;

  assign w_wr     = bus.chipselect & ~bus.write_n;
  assign w_clr    = (w_wr && bus.address == 2'd3) ? bus.writedata[WIDTH-1:0] : '0;
  assign w_unused = ^bus.writedata;

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    nios_system_pio_edge_in_lane #(
      .EDGE_TYPE  (EDGE_TYPE),
      .SYNC_STAGES(SYNC_STAGES)
    ) u_lane (
      .clk    (clk),
      .reset_n(reset_n),
      .i_in   (in_port[g]),
      .i_clr  (w_clr[g]),
      .o_sync (w_sync[g]),
      .o_cap  (w_cap[g])
    );
  end

  // Read mux ignores chipselect; unused upper bits stay zero.
  always_comb begin
    w_rdata = '0;
    case (bus.address)
      2'd0:    w_rdata[WIDTH-1:0] = w_sync;
      2'd2:    w_rdata[WIDTH-1:0] = r_irqmask;
      2'd3:    w_rdata[WIDTH-1:0] = w_cap;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_irqmask  <= '0;
      r_readdata <= '0;
      r_irq      <= 1'b0;
    end else begin
      if (w_wr && bus.address == 2'd2)
        r_irqmask <= bus.writedata[WIDTH-1:0];
      r_readdata <= w_rdata;
      r_irq      <= |(w_cap & r_irqmask);
    end
  end

  assign bus.readdata = r_readdata;
  assign bus.irq      = r_irq;
endmodule
